// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the NTT job scheduler: FSM states,
// completion codes and the 16-bit job descriptor.
package ntt_sched_pkg;

   localparam int unsigned MAX_MODULI = 60;
   localparam int unsigned MOD_W      = 6;
   localparam int unsigned TAG_W      = 4;
   localparam int unsigned ERR_W      = 2;
   localparam int unsigned DESC_W     = 16;

   localparam logic [ERR_W-1:0] ERR_OK      = 2'd0;
   localparam logic [ERR_W-1:0] ERR_BADDESC = 2'd1;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      REPORT
   } sched_state_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [MOD_W-1:0] first;
      logic [MOD_W-1:0] num;
   } job_desc_t;

   // Empty range or a range running past the last modulus; sum taken at 7 bits.
   function automatic logic desc_bad(input job_desc_t d, input int unsigned num_moduli);
      logic [MOD_W:0] span;
      span = (MOD_W+1)'(d.first) + (MOD_W+1)'(d.num);
      return (d.num == '0) || (span > (MOD_W+1)'(num_moduli));
   endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous descriptor FIFO; head entry is read combinationally and
// full/empty are registered alongside the occupancy count.
module sched_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_c_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             push_en, pop_en;

   assign push_en = push_i && !full_q;
   assign pop_en  = pop_i && !empty_q;

   always_comb begin
      count_d = count_q;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_c_o = mem_q[rd_ptr_q];
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign count_o   = count_q;

endmodule

// File: rtl/ntt_job_scheduler.sv
// Runs the NTT controller once per RNS modulus of each queued job and returns
// one completion per job. Define NTT_SCHED_PERF_EN to add performance counters.
module ntt_job_scheduler
   import ntt_sched_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned NUM_MODULI  = 48,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [MOD_W-1:0] job_first_mod,
   input  logic [MOD_W-1:0] job_num_mod,
   input  logic [TAG_W-1:0] job_tag,
   output logic             ctrl_start,
   output logic [MOD_W-1:0] ctrl_mod_idx,
   input  logic             ctrl_done,
   output logic             cmpl_valid,
   input  logic             cmpl_ready,
   output logic [TAG_W-1:0] cmpl_tag,
   output logic [ERR_W-1:0] cmpl_err,
   output logic             busy
`ifdef NTT_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_busy_cycles,
   output logic [15:0]      perf_jobs_done
`endif
);

   localparam int unsigned NUM_MOD_EFF = (NUM_MODULI > MAX_MODULI) ? MAX_MODULI : NUM_MODULI;
   localparam int unsigned TO_W        = $clog2(ACK_TIMEOUT) + 1;
   localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;

   sched_state_e     state_q, state_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [MOD_W-1:0] mod_q, mod_d;
   logic [MOD_W-1:0] rem_q, rem_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

   job_desc_t        push_desc, head_desc;
   logic [DESC_W-1:0] fifo_rdata;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   assign push_desc = '{tag: job_tag, first: job_first_mod, num: job_num_mod};
   assign head_desc = fifo_rdata;
   assign fifo_push = job_valid && job_ready;

   sched_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DESC_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (fifo_push),
      .wdata_i   (push_desc),
      .pop_i     (fifo_pop),
      .rdata_c_o (fifo_rdata),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         err_q    <= ERR_OK;
         mod_q    <= '0;
         rem_q    <= '0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         err_q    <= err_d;
         mod_q    <= mod_d;
         rem_q    <= rem_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      err_d    = err_q;
      mod_d    = mod_q;
      rem_d    = rem_q;
      to_cnt_d = to_cnt_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               tag_d    = head_desc.tag;
               mod_d    = head_desc.first;
               rem_d    = head_desc.num;
               if (desc_bad(head_desc, NUM_MOD_EFF)) begin
                  err_d   = ERR_BADDESC;
                  state_d = REPORT;
               end else begin
                  err_d   = ERR_OK;
                  state_d = ISSUE;
               end
            end
         end
         // Start is only issued while the controller reports idle.
         ISSUE: begin
            if (ctrl_done) begin
               to_cnt_d = '0;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!ctrl_done) begin
               state_d = WAIT_DONE;
            end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
               err_d   = ERR_TIMEOUT;
               state_d = REPORT;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         WAIT_DONE: begin
            if (ctrl_done) begin
               if (rem_q == MOD_W'(1)) begin
                  err_d   = ERR_OK;
                  state_d = REPORT;
               end else begin
                  mod_d   = mod_q + MOD_W'(1);
                  rem_d   = rem_q - MOD_W'(1);
                  state_d = ISSUE;
               end
            end
         end
         REPORT: begin
            if (cmpl_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign job_ready    = !reset && !fifo_full;
   assign ctrl_start   = (state_q == ISSUE) && ctrl_done;
   assign ctrl_mod_idx = mod_q;
   assign cmpl_valid   = (state_q == REPORT);
   assign cmpl_tag     = tag_q;
   assign cmpl_err     = err_q;
   assign busy         = (state_q != IDLE) || (fifo_count != '0);

`ifdef NTT_SCHED_PERF_EN
   logic [31:0] perf_busy_q;
   logic [15:0] perf_jobs_q;

   // Busy cycles saturate; completed-job count wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_busy_q <= '0;
         perf_jobs_q <= '0;
      end else begin
         if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
         if (cmpl_valid && cmpl_ready && (cmpl_err == ERR_OK)) perf_jobs_q <= perf_jobs_q + 16'd1;
      end
   end

   assign perf_busy_cycles = perf_busy_q;
   assign perf_jobs_done   = perf_jobs_q;
`endif

endmodule
